moore_seq_detector: RTL

Parametrised Moore sequence detector, the successor to the fixed 3-bit-state machine.
- Serial input x1 is sampled on a valid strobe and compared against a run-time-programmable pattern of up to MAX_LEN bits.
- Two modes, overlapping and non-overlapping.
- Exposes the current match depth as state, a Moore match flag z1, and a saturating match counter.
- Instantiated under the tt_um_ top; state_o maps to uo_out[LEN_W-1:0] and z1 maps to uo_out[LEN_W].

---
 rtl/moore_seq_detector_pkg.sv | 23 ++
 rtl/moore_seq_detector_if.sv | 30 +++
 rtl/moore_seq_next_state.sv | 46 ++++
 rtl/moore_seq_detector.sv | 91 +++++++++
 4 files changed

// File: rtl/moore_seq_detector_pkg.sv
// Shared types, reset defaults and width helper for the Moore sequence detector.
package moore_seq_pkg;

  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } mode_e;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam logic [7:0]  DEF_PATTERN = 8'b0000_1101;
  localparam int unsigned DEF_LEN     = 4;

  // Bits needed to hold the values 0..max_len inclusive.
  function automatic int unsigned len_width(input int unsigned max_len);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < (max_len + 32'd1)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/moore_seq_detector_if.sv
// Sample/config/status bundle between the detector and its driver.
interface moore_seq_detector_if
  import moore_seq_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned LEN_W = len_width(MAX_LEN);

  logic               x_valid;
  logic               x1;
  logic               mode_overlap;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cnt_clr;
  logic [LEN_W-1:0]   state_o;
  logic               z1;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output x_valid, x1, mode_overlap, cfg_load, cfg_pattern, cfg_len, cnt_clr,
    input  state_o, z1, match_count
  );

  modport slave (
    input  x_valid, x1, mode_overlap, cfg_load, cfg_pattern, cfg_len, cnt_clr,
    output state_o, z1, match_count
  );
endinterface

// File: rtl/moore_seq_next_state.sv
// Combinational next-state: longest history suffix that equals a pattern prefix.
module moore_seq_next_state
  import moore_seq_pkg::*;
#(
  parameter  int unsigned MAX_LEN = DEF_MAX_LEN,
  localparam int unsigned LEN_W   = len_width(MAX_LEN)
) (
  input  logic [MAX_LEN-1:0] hist_i,        // bit 0 = most recent sample
  input  logic [LEN_W-1:0]   fill_i,
  input  logic [MAX_LEN-1:0] pattern_i,     // bit 0 = first expected bit
  input  logic [LEN_W-1:0]   len_i,
  input  logic               x1_i,
  input  logic               mode_overlap_i,
  input  logic [LEN_W-1:0]   state_i,
  output logic [LEN_W-1:0]   state_o
);
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] cand;
  logic [LEN_W-1:0]   avail;
  logic               restart;
  logic               ok;

  // Build the post-append history, then keep the largest k whose suffix matches.
  always_comb begin
    restart = (state_i == len_i) && (mode_e'(mode_overlap_i) == NON_OVERLAP);
    cand    = '0;
    avail   = '0;
    ok      = 1'b0;
    state_o = '0;
    if (restart) begin
      cand[0] = x1_i;
      avail   = LEN_W'(1);
    end else begin
      cand  = {hist_i[MAX_LEN-2:0], x1_i};
      avail = (fill_i == MAX_LEN_C) ? fill_i : fill_i + 1'b1;
    end
    for (int unsigned k = 1; k <= MAX_LEN; k++) begin
      ok = (LEN_W'(k) <= len_i) && (LEN_W'(k) <= avail);
      for (int unsigned j = 0; j < k; j++) begin
        if (cand[k-1-j] != pattern_i[j]) ok = 1'b0;
      end
      if (ok) state_o = LEN_W'(k);
    end
  end
endmodule

// File: rtl/moore_seq_detector.sv
// Programmable-pattern Moore sequence detector with saturating match counter.
module moore_seq_detector
  import moore_seq_pkg::*;
#(
  parameter int unsigned        MAX_LEN     = DEF_MAX_LEN,
  parameter int unsigned        CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN),
  parameter int unsigned        RST_LEN     = DEF_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  moore_seq_detector_if.slave  bus
);
  localparam int unsigned      LEN_W     = len_width(MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] RST_LEN_C = LEN_W'(RST_LEN);

  logic [LEN_W-1:0]   state_q, state_d, next_state;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               restart;

  moore_seq_next_state #(.MAX_LEN(MAX_LEN)) u_next (
    .hist_i         (hist_q),
    .fill_i         (fill_q),
    .pattern_i      (pat_q),
    .len_i          (len_q),
    .x1_i           (bus.x1),
    .mode_overlap_i (bus.mode_overlap),
    .state_i        (state_q),
    .state_o        (next_state)
  );

  // Config load, history shift, state advance and counter update.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    restart = (state_q == len_q) && (mode_e'(bus.mode_overlap) == NON_OVERLAP);
    if (bus.cfg_load) begin
      pat_d   = bus.cfg_pattern;
      if (bus.cfg_len == '0)             len_d = LEN_W'(1);
      else if (bus.cfg_len > MAX_LEN_C)  len_d = MAX_LEN_C;
      else                               len_d = bus.cfg_len;
      state_d = '0;
      hist_d  = '0;
      fill_d  = '0;
    end else if (bus.x_valid) begin
      state_d = next_state;
      if (restart) begin
        hist_d    = '0;
        hist_d[0] = bus.x1;
        fill_d    = LEN_W'(1);
      end else begin
        hist_d = {hist_q[MAX_LEN-2:0], bus.x1};
        fill_d = (fill_q == MAX_LEN_C) ? fill_q : fill_q + 1'b1;
      end
      if ((next_state == len_q) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
    if (bus.cnt_clr) cnt_d = '0;
  end

  // State, history, config and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= RST_PATTERN;
      len_q   <= RST_LEN_C;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.state_o     = state_q;
  assign bus.z1          = (state_q == len_q);
  assign bus.match_count = cnt_q;
endmodule
